// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch-flush bubble
// insertion, memory-stall freeze and a saturating bubble counter.
`timescale 1ns/1ps
module idex_hazard_reg #(
  parameter int unsigned   W      = 32,
  parameter logic [W-1:0]  NOP_IR = '0,
  parameter int unsigned   CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     d_ir,
  input  logic [W-1:0]     d_pc,
  input  logic [W-1:0]     d_rd1,
  input  logic [W-1:0]     d_rd2,
  input  logic [W-1:0]     d_imm,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [4:0]       d_ws,
  input  logic             d_we,
  input  logic             d_re1,
  input  logic             d_re2,
  input  logic             d_memread,
  input  logic             d_memwrite,
  input  logic             d_valid,
  input  logic             flush,
  input  logic             mem_busy,
  output logic [W-1:0]     ex_ir,
  output logic [W-1:0]     ex_pc,
  output logic [W-1:0]     ex_rd1,
  output logic [W-1:0]     ex_rd2,
  output logic [W-1:0]     ex_imm,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_ws,
  output logic             ex_we,
  output logic             ex_re1,
  output logic             ex_re2,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_valid,
  output logic             stall_fd,
  output logic             load_use,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int unsigned RW = 5;

  typedef struct packed {
    logic [W-1:0]  ir;
    logic [W-1:0]  pc;
    logic [W-1:0]  rd1;
    logic [W-1:0]  rd2;
    logic [W-1:0]  imm;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] ws;
    logic          we;
    logic          re1;
    logic          re2;
    logic          memread;
    logic          memwrite;
    logic          valid;
  } idex_t;

  idex_t            ex_q, ex_d;
  idex_t            id_slot;
  idex_t            bubble;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz;
  logic             load_bubble;

  // Bundle the incoming ID fields into one payload.
  always_comb begin
    id_slot          = '0;
    id_slot.ir       = d_ir;
    id_slot.pc       = d_pc;
    id_slot.rd1      = d_rd1;
    id_slot.rd2      = d_rd2;
    id_slot.imm      = d_imm;
    id_slot.rs       = d_rs;
    id_slot.rt       = d_rt;
    id_slot.ws       = d_ws;
    id_slot.we       = d_we;
    id_slot.re1      = d_re1;
    id_slot.re2      = d_re2;
    id_slot.memread  = d_memread;
    id_slot.memwrite = d_memwrite;
    id_slot.valid    = d_valid;
  end

  // Bubble payload: everything cleared except the instruction word, which is a NOP.
  always_comb begin
    bubble    = '0;
    bubble.ir = NOP_IR;
  end

  // Load in EX whose destination is read by the ID instruction; $0 never hazards.
  always_comb begin
    hz = d_valid & ex_q.valid & ex_q.memread & ex_q.we & (ex_q.ws != RW'(0)) &
         ((d_re1 & (d_rs == ex_q.ws)) | (d_re2 & (d_rt == ex_q.ws)));
  end

  // Stall/bubble decisions; a flush already kills the ID instruction so no hold.
  always_comb begin
    load_bubble = ~mem_busy & (flush | hz);
    stall_fd    = mem_busy | (hz & ~flush);
    load_use    = hz & ~flush & ~mem_busy;
  end

  // Next state: freeze on mem_busy, else bubble on flush/hazard, else capture.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (!mem_busy) begin
      if (load_bubble) begin
        ex_d = bubble;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        ex_d = id_slot;
      end
    end
  end

  // State register; reset leaves a bubble in EX and clears the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= bubble;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  // Unpack the EX payload onto the output ports.
  always_comb begin
    ex_ir       = ex_q.ir;
    ex_pc       = ex_q.pc;
    ex_rd1      = ex_q.rd1;
    ex_rd2      = ex_q.rd2;
    ex_imm      = ex_q.imm;
    ex_rs       = ex_q.rs;
    ex_rt       = ex_q.rt;
    ex_ws       = ex_q.ws;
    ex_we       = ex_q.we;
    ex_re1      = ex_q.re1;
    ex_re2      = ex_q.re2;
    ex_memread  = ex_q.memread;
    ex_memwrite = ex_q.memwrite;
    ex_valid    = ex_q.valid;
    bubble_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Self-checking bench for idex_hazard_reg: reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_idex_hazard_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] d_ir, d_pc, d_rd1, d_rd2, d_imm;
  logic [4:0]  d_rs, d_rt, d_ws;
  logic        d_we, d_re1, d_re2, d_memread, d_memwrite, d_valid, flush, mem_busy;
  logic [31:0] ex_ir, ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_ws;
  logic        ex_we, ex_re1, ex_re2, ex_memread, ex_memwrite, ex_valid;
  logic        stall_fd, load_use;
  logic [15:0] bubble_cnt;

  int tests = 0;
  int fails = 0;

  idex_hazard_reg dut (
    .clk(clk), .rst_n(rst_n),
    .d_ir(d_ir), .d_pc(d_pc), .d_rd1(d_rd1), .d_rd2(d_rd2), .d_imm(d_imm),
    .d_rs(d_rs), .d_rt(d_rt), .d_ws(d_ws), .d_we(d_we), .d_re1(d_re1), .d_re2(d_re2),
    .d_memread(d_memread), .d_memwrite(d_memwrite), .d_valid(d_valid),
    .flush(flush), .mem_busy(mem_busy),
    .ex_ir(ex_ir), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_ws(ex_ws), .ex_we(ex_we), .ex_re1(ex_re1),
    .ex_re2(ex_re2), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_valid(ex_valid), .stall_fd(stall_fd), .load_use(load_use),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what EX must hold, derived from the pipeline rules.
  logic [31:0] m_ir, m_pc, m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs, m_rt, m_ws;
  logic        m_we, m_re1, m_re2, m_mr, m_mw, m_v;
  logic [15:0] m_cnt;

  function automatic logic m_hz();
    if (!(d_valid && m_v && m_mr && m_we) || m_ws == 5'd0) return 1'b0;
    return (d_re1 && d_rs == m_ws) || (d_re2 && d_rt == m_ws);
  endfunction

  task automatic m_clear();
    m_ir = 32'h0; m_pc = 32'h0; m_rd1 = 32'h0; m_rd2 = 32'h0; m_imm = 32'h0;
    m_rs = 5'd0; m_rt = 5'd0; m_ws = 5'd0;
    m_we = 0; m_re1 = 0; m_re2 = 0; m_mr = 0; m_mw = 0; m_v = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clear();
      m_cnt = 16'h0;
    end else if (!mem_busy) begin
      if (flush || m_hz()) begin
        m_clear();
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
      end else begin
        m_ir = d_ir; m_pc = d_pc; m_rd1 = d_rd1; m_rd2 = d_rd2; m_imm = d_imm;
        m_rs = d_rs; m_rt = d_rt; m_ws = d_ws;
        m_we = d_we; m_re1 = d_re1; m_re2 = d_re2;
        m_mr = d_memread; m_mw = d_memwrite; m_v = d_valid;
      end
    end
  end

  // Compare every cycle, half a period away from the active edge.
  always @(negedge clk) begin
    chk("ex_ir", ex_ir, m_ir);
    chk("ex_pc", ex_pc, m_pc);
    chk("ex_rd1", ex_rd1, m_rd1);
    chk("ex_rd2", ex_rd2, m_rd2);
    chk("ex_imm", ex_imm, m_imm);
    chk("ex_rs", 32'(ex_rs), 32'(m_rs));
    chk("ex_rt", 32'(ex_rt), 32'(m_rt));
    chk("ex_ws", 32'(ex_ws), 32'(m_ws));
    chk("ex_ctl", {26'd0, ex_we, ex_re1, ex_re2, ex_memread, ex_memwrite, ex_valid},
                  {26'd0, m_we, m_re1, m_re2, m_mr, m_mw, m_v});
    chk("bubble_cnt", 32'(bubble_cnt), 32'(m_cnt));
    chk("stall_fd", 32'(stall_fd), 32'(mem_busy || (m_hz() && !flush)));
    chk("load_use", 32'(load_use), 32'(m_hz() && !flush && !mem_busy));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic id_set(input logic [31:0] ir, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] ws, input logic we, input logic re1,
                        input logic re2, input logic mr);
    d_ir = ir; d_rs = rs; d_rt = rt; d_ws = ws; d_we = we;
    d_re1 = re1; d_re2 = re2; d_memread = mr; d_memwrite = 1'b0; d_valid = 1'b1;
    d_pc = ir ^ 32'h1000_0004; d_rd1 = {27'd0, rs} + 32'h100;
    d_rd2 = {27'd0, rt} + 32'h200; d_imm = 32'h0000_0010;
  endtask

  localparam logic [31:0] LW8  = 32'h8D28_0000;  // lw  $8, 0($9)
  localparam logic [31:0] LW0  = 32'h8D20_0000;  // lw  $0, 0($9)
  localparam logic [31:0] ADD  = 32'h0109_5020;  // add $10, $8, $9

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; mem_busy = 1'b0;
    d_ir = '0; d_pc = '0; d_rd1 = '0; d_rd2 = '0; d_imm = '0;
    d_rs = '0; d_rt = '0; d_ws = '0;
    d_we = 0; d_re1 = 0; d_re2 = 0; d_memread = 0; d_memwrite = 0; d_valid = 0;
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst ex_ir", ex_ir, 32'h0);
    chk("rst cnt", 32'(bubble_cnt), 32'h0);
    chk("rst stall", 32'(stall_fd), 32'h0);

    // Normal capture.
    id_set(32'h012A_4020, 5'd9, 5'd10, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); #1;
    chk("norm ex_ir", ex_ir, 32'h012A_4020);
    chk("norm ex_rs", 32'(ex_rs), 32'd9);
    chk("norm ex_rt", 32'(ex_rt), 32'd10);
    chk("norm ex_ws", 32'(ex_ws), 32'd8);
    chk("norm ex_we", 32'(ex_we), 32'd1);
    chk("norm stall", 32'(stall_fd), 32'd0);

    // Load-use: lw $8 in EX, ID reads $8.
    id_set(LW8, 5'd9, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    id_set(ADD, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("lu stall", 32'(stall_fd), 32'd1);
    chk("lu load_use", 32'(load_use), 32'd1);
    step(); #1;
    chk("lu bubble valid", 32'(ex_valid), 32'd0);
    chk("lu bubble ir", ex_ir, 32'h0);
    chk("lu cnt", 32'(bubble_cnt), 32'd1);
    chk("lu stall released", 32'(stall_fd), 32'd0);
    step(); #1;
    chk("lu capture rs", 32'(ex_rs), 32'd8);
    chk("lu capture valid", 32'(ex_valid), 32'd1);

    // Load to $0 never hazards.
    id_set(LW0, 5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    id_set(ADD, 5'd0, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("r0 stall", 32'(stall_fd), 32'd0);
    step(); #1;
    chk("r0 no bubble", 32'(ex_valid), 32'd1);
    chk("r0 cnt", 32'(bubble_cnt), 32'd1);

    // Flush together with a hazard: one bubble, no hold.
    id_set(LW8, 5'd9, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    id_set(ADD, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk("fl stall", 32'(stall_fd), 32'd0);
    chk("fl load_use", 32'(load_use), 32'd0);
    step(); flush = 1'b0; #1;
    chk("fl bubble", 32'(ex_valid), 32'd0);
    chk("fl cnt", 32'(bubble_cnt), 32'd2);

    // Memory stall with pending hazard: freeze 3 cycles, then one bubble.
    id_set(LW8, 5'd9, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    id_set(ADD, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mb stall", 32'(stall_fd), 32'd1);
      chk("mb load_use", 32'(load_use), 32'd0);
      chk("mb hold ir", ex_ir, LW8);
      chk("mb hold cnt", 32'(bubble_cnt), 32'd2);
      step();
    end
    mem_busy = 1'b0;
    #1;
    chk("mb release load_use", 32'(load_use), 32'd1);
    step(); #1;
    chk("mb bubble", 32'(ex_valid), 32'd0);
    chk("mb cnt", 32'(bubble_cnt), 32'd3);
    step(); #1;
    chk("mb capture rs", 32'(ex_rs), 32'd8);

    // Saturation: drive flush bubbles until the counter is full.
    flush = 1'b1;
    for (int i = 0; i < 65535; i++) step();
    #1;
    chk("sat full", 32'(bubble_cnt), 32'h0000_FFFF);
    step(); #1;
    chk("sat hold", 32'(bubble_cnt), 32'h0000_FFFF);
    flush = 1'b0;

    // Asynchronous reset mid-cycle with a valid load in EX.
    id_set(LW8, 5'd9, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    step(); #1;
    chk("pre-rst valid", 32'(ex_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst valid", 32'(ex_valid), 32'd0);
    chk("arst ir", ex_ir, 32'h0);
    chk("arst ws", 32'(ex_ws), 32'd0);
    chk("arst memread", 32'(ex_memread), 32'd0);
    chk("arst cnt", 32'(bubble_cnt), 32'd0);
    chk("arst stall", 32'(stall_fd), 32'd0);
    step();
    rst_n = 1'b1;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/idex_hazard_reg.md
Name: idex_hazard_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline, with integrated load-use hazard detection.
- Captures decoded ID-stage fields each cycle and presents them to EX.
- EX consumes the outputs: rs/rt/re1/re2 feed the forwarding unit, and ws/we become the EX-stage write-back tags.
- Inserts a bubble on a load-use hazard or a branch flush, freezes on a memory stall, and counts inserted bubbles.

Parameters:
W, 32, datapath / instruction width
NOP_IR, 32'h0000_0000, instruction word loaded into ex_ir on reset and on bubble
CNT_W, 16, width of the bubble statistics counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
d_ir  in  W  ID-stage instruction word
d_pc  in  W  ID-stage PC+4
d_rd1  in  W  register file read data 1
d_rd2  in  W  register file read data 2
d_imm  in  W  sign/zero-extended immediate
d_rs  in  5  source register 1 index
d_rt  in  5  source register 2 index
d_ws  in  5  destination register index
d_we  in  1  instruction writes register file
d_re1  in  1  instruction reads rs
d_re2  in  1  instruction reads rt
d_memread  in  1  instruction is a load
d_memwrite  in  1  instruction is a store
d_valid  in  1  ID slot holds a real instruction
flush  in  1  branch/jump taken, resolved in EX; kill the ID instruction
mem_busy  in  1  data memory stall; freeze the pipeline
ex_ir, ex_pc, ex_rd1, ex_rd2, ex_imm  out  W  registered copies of the d_* fields
ex_rs, ex_rt, ex_ws  out  5  registered indices
ex_we, ex_re1, ex_re2, ex_memread, ex_memwrite, ex_valid  out  1  registered controls
stall_fd  out  1  hold PC and IF/ID register this cycle
load_use  out  1  bubble inserted this cycle due to load-use
bubble_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (async, rst_n=0):
  - All ex_* outputs 0, except ex_ir=NOP_IR.
  - bubble_cnt=0.
  - Takes effect immediately, mid-stall included; no stall state survives reset.
- Hazard term (combinational): hz = d_valid & ex_valid & ex_memread & ex_we & (ex_ws!=0) & ((d_re1 & d_rs==ex_ws) | (d_re2 & d_rt==ex_ws)).
- Per rising edge, priority is mem_busy > flush > hz > capture:
  - mem_busy=1: all ex_* and bubble_cnt hold.
  - flush=1: load bubble.
  - hz=1: load bubble.
  - Otherwise: capture all d_* fields into ex_* (ex_valid<=d_valid), 1-cycle latency.
- Bubble:
  - ex_valid, ex_we, ex_re1, ex_re2, ex_memread, ex_memwrite <= 0.
  - ex_ir <= NOP_IR.
  - ex_rs, ex_rt, ex_ws, ex_pc, ex_rd1, ex_rd2, ex_imm <= 0.
- stall_fd = mem_busy | (hz & ~flush), combinational.
  - On flush the ID instruction is wrong-path, so no hold is needed.
- load_use = hz & ~flush & ~mem_busy, combinational.
- Load-use stall length:
  - Exactly 1 cycle, because the bubble clears ex_memread.
  - The held ID instruction is re-evaluated next cycle and captured; MEM-to-EX forwarding covers it.
- bubble_cnt:
  - +1 on each edge where a bubble is loaded (flush or hz, and mem_busy=0).
  - Saturates at all ones.
  - Holds while mem_busy=1.
- Register $0:
  - A load whose ex_ws=0 never raises hz.
  - d_* fields with rs/rt=0 are captured unchanged; the forwarding unit handles them.
- flush and hz together: one bubble, stall_fd=0, load_use=0, bubble_cnt +1.
- mem_busy and hz together: stall_fd=1, nothing moves, load_use=0; hz is re-evaluated after mem_busy falls.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with ex_valid=1 -> all ex_* immediately 0, ex_ir=NOP_IR, bubble_cnt=0, stall_fd=0.
- Normal flow: d_ir=32'h012A4020, d_rs=9, d_rt=10, d_ws=8, d_we=1, d_valid=1 -> next edge ex_ir=32'h012A4020, ex_rs=9, ex_rt=10, ex_ws=8, ex_we=1; stall_fd=0.
- Load-use:
  - Setup: EX holds lw with ex_ws=8, ex_memread=1, ex_we=1; ID has d_rs=8, d_re1=1.
  - Response: stall_fd=1 and load_use=1 for exactly 1 cycle; bubble loaded (ex_valid=0, ex_ir=NOP_IR); bubble_cnt 0->1.
  - Following edge: ID instruction captured with ex_rs=8.
- $0 load: same as the load-use case but ex_ws=0, d_rs=0 -> stall_fd=0, no bubble, bubble_cnt unchanged.
- Flush with hazard: load-use condition active and flush=1 -> single bubble, stall_fd=0, load_use=0, bubble_cnt +1.
- Freeze and saturation:
  - mem_busy=1 for 3 cycles with a hazard pending -> ex_* and bubble_cnt constant, stall_fd=1; after release, one bubble.
  - Preload bubble_cnt to 16'hFFFF, force a bubble -> stays 16'hFFFF.
